// File: rtl/scu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scu_pkg
//  Description : Shared opcodes, ALU function codes, PC source encodings and
//                the sequencer state type for the SCU multi-cycle control.
//  Revision    : 1.0 - initial release
// ============================================================================
package scu_pkg;

    // Instruction opcodes (instr[31:28])
    localparam logic [3:0] c_op_nop  = 4'b0000;
    localparam logic [3:0] c_op_st   = 4'b0011;
    localparam logic [3:0] c_op_add  = 4'b0100;
    localparam logic [3:0] c_op_inc  = 4'b0101;
    localparam logic [3:0] c_op_neg  = 4'b0110;
    localparam logic [3:0] c_op_sub  = 4'b0111;
    localparam logic [3:0] c_op_j    = 4'b1000;
    localparam logic [3:0] c_op_brz  = 4'b1001;
    localparam logic [3:0] c_op_jm   = 4'b1010;
    localparam logic [3:0] c_op_brn  = 4'b1011;
    localparam logic [3:0] c_op_ld   = 4'b1110;
    localparam logic [3:0] c_op_svpc = 4'b1111;

    // ALU function codes
    localparam logic [3:0] c_alu_add = 4'b0100;
    localparam logic [3:0] c_alu_inc = 4'b0101;
    localparam logic [3:0] c_alu_neg = 4'b0110;
    localparam logic [3:0] c_alu_sub = 4'b0111;

    // PC source select
    localparam logic [1:0] c_pc_inc = 2'b00;
    localparam logic [1:0] c_pc_reg = 2'b01;
    localparam logic [1:0] c_pc_mem = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Opcodes with no defined instruction
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0010) ||
               (op == 4'b1100) || (op == 4'b1101);
    endfunction

    // ADD/INC/NEG/SUB occupy 01xx; only these update the flags
    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mem_timer
//  Description : Wait-cycle counter for a memory handshake. Cleared while no
//                request is outstanding or when the ack arrives; flags
//                expiry on the LIMIT-th consecutive un-acked request cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mem_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              c_w        = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_w-1:0]  c_limit_m1 = c_w'(LIMIT - 1);

    logic [c_w-1:0] r_count;

    // Count un-acked request cycles, holding at the limit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + c_w'(1);
        end
    end

    assign expired = (r_count >= c_limit_m1);

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : FETCH/DECODE/EXEC/MEM/WB control FSM for the SCU datapath
//                sharing one memory port between fetch and data access. Holds
//                the Z/N flags, resolves branches, times out memory waits and
//                halts on illegal opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import scu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic             svpc,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_op;
    logic             r_z;
    logic             r_n;
    logic             r_err_illegal;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_retired;
    logic             w_wait_state;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_timer_expired;
    logic             w_retire;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timer_clr  = !w_wait_state || mem_ack;
    assign w_timer_en   = w_wait_state && !mem_ack;
    assign w_retire     = (w_next_state == S_FETCH) &&
                          ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

    seq_mem_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .expired (w_timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched opcode, condition flags, sticky error causes and retire count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op          <= c_op_nop;
            r_z           <= 1'b0;
            r_n           <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_op <= opcode;
                if (is_illegal(opcode)) begin
                    r_err_illegal <= 1'b1;
                end
            end
            if ((r_state == S_EXEC) && is_alu_op(r_op)) begin
                r_z <= alu_z;
                r_n <= alu_n;
            end
            if (w_wait_state && !mem_ack && w_timer_expired) begin
                r_err_timeout <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Next-state and control strobe decode
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_pc_inc;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        alu_op       = c_alu_add;
        svpc         = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load      = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = c_pc_inc;
                    w_next_state = S_DECODE;
                end else if (w_timer_expired) begin
                    w_next_state = S_HALT;
                end
            end

            S_DECODE: begin
                w_next_state = is_illegal(opcode) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (r_op)
                    c_op_add, c_op_sub: begin
                        alu_op       = r_op;
                        w_next_state = S_WB;
                    end
                    c_op_inc, c_op_neg: begin
                        alu_op       = r_op;
                        alu_src      = 1'b1;
                        w_next_state = S_WB;
                    end
                    c_op_ld, c_op_st: begin
                        alu_src      = 1'b1;
                        w_next_state = S_MEM;
                    end
                    c_op_jm: begin
                        w_next_state = S_MEM;
                    end
                    c_op_svpc: begin
                        w_next_state = S_WB;
                    end
                    c_op_j: begin
                        pc_write     = 1'b1;
                        pc_src       = c_pc_reg;
                        w_next_state = S_FETCH;
                    end
                    c_op_brz: begin
                        pc_write     = r_z;
                        pc_src       = r_z ? c_pc_reg : c_pc_inc;
                        w_next_state = S_FETCH;
                    end
                    c_op_brn: begin
                        pc_write     = r_n;
                        pc_src       = r_n ? c_pc_reg : c_pc_inc;
                        w_next_state = S_FETCH;
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_op == c_op_st);
                if (mem_ack) begin
                    if (r_op == c_op_ld) begin
                        w_next_state = S_WB;
                    end else begin
                        if (r_op == c_op_jm) begin
                            pc_write = 1'b1;
                            pc_src   = c_pc_mem;
                        end
                        w_next_state = S_FETCH;
                    end
                end else if (w_timer_expired) begin
                    w_next_state = S_HALT;
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = (r_op == c_op_ld);
                svpc         = (r_op == c_op_svpc);
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Directed self-checking bench for multicycle_sequencer with
//                a 4-cycle memory timeout and a 4-bit retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       alu_z;
    logic       alu_n;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       svpc;
    logic       halted;
    logic       err_illegal;
    logic       err_timeout;
    logic [3:0] retired;

    int checks   = 0;
    int failures = 0;

    multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .alu_z        (alu_z),
        .alu_n        (alu_n),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .svpc         (svpc),
        .halted       (halted),
        .err_illegal  (err_illegal),
        .err_timeout  (err_timeout),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; land 2 time units after the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From a FETCH cycle with ack high: load op, advance to its EXEC cycle
    task automatic fetch_to_exec(input logic [3:0] op);
        mem_ack = 1'b1;
        opcode  = op;
        #1;
        chk("fetch_ir_load", ir_load, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; alu_z = 1'b0; alu_n = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_alu_op", alu_op, 4'b0100);
        chk("rst_halted", halted, 1'b0);
        chk("rst_retired", retired, 4'd0);
        chk("rst_errs", {err_illegal, err_timeout}, 2'b00);

        // 1. NOP stream, ack tied high
        rst = 1'b0; mem_ack = 1'b1; #1;
        chk("idle_mem_req", mem_req, 1'b0);          // cycle 1
        tick();
        chk("c2_mem_req", mem_req, 1'b1);            // cycle 2
        chk("c2_fetch_strobes", {pc_write, pc_src, mem_addr_sel}, 4'b1000);
        fetch_to_exec(4'b0000);                      // cycle 4: EXEC
        chk("nop_exec", {mem_req, pc_write, reg_write}, 3'b000);
        chk("nop_exec_retired", retired, 4'd0);
        tick();
        chk("nop_retired1", retired, 4'd1);
        chk("nop_refetch", mem_req, 1'b1);
        fetch_to_exec(4'b0000);
        tick();
        chk("nop_retired2", retired, 4'd2);

        // 2. SUB -> zero, BRZ taken; ADD non-zero, BRZ not taken, BRN taken
        fetch_to_exec(4'b0111);
        alu_z = 1'b1; alu_n = 1'b0; #1;
        chk("sub_alu", {alu_op, alu_src}, 5'b01110);
        tick();
        alu_z = 1'b0; #1;
        chk("sub_wb", {reg_write, mem_to_reg, svpc}, 3'b100);
        tick();
        chk("sub_retired", retired, 4'd3);
        fetch_to_exec(4'b1001);
        chk("brz_taken", {pc_write, pc_src}, 3'b101);
        tick();
        fetch_to_exec(4'b0100);
        alu_z = 1'b0; alu_n = 1'b1; #1;
        chk("add_alu", {alu_op, alu_src}, 5'b01000);
        tick();
        alu_n = 1'b0;
        tick();
        chk("add_retired", retired, 4'd5);
        fetch_to_exec(4'b1001);
        chk("brz_not_taken", pc_write, 1'b0);
        tick();
        fetch_to_exec(4'b1011);
        chk("brn_taken", {pc_write, pc_src}, 3'b101);
        tick();
        chk("br_retired", retired, 4'd7);
        fetch_to_exec(4'b0101);
        chk("inc_alu", {alu_op, alu_src}, 5'b01011);
        tick();
        tick();
        chk("inc_retired", retired, 4'd8);

        // 3. LD with ack on the 4th MEM cycle
        fetch_to_exec(4'b1110);
        chk("ld_exec", {alu_op, alu_src, mem_req}, 6'b010010);
        mem_ack = 1'b0;
        tick();
        chk("ld_mem1", {mem_req, mem_addr_sel, mem_we}, 3'b110);
        tick();
        tick();
        chk("ld_mem3", {mem_req, mem_addr_sel}, 2'b11);
        tick();
        mem_ack = 1'b1; #1;
        chk("ld_mem4", {mem_req, mem_addr_sel, pc_write}, 3'b110);
        tick();
        chk("ld_wb", {reg_write, mem_to_reg, mem_req, halted}, 4'b1100);
        tick();
        chk("ld_retired", retired, 4'd9);

        // 4. JM then ST, then SVPC and J
        fetch_to_exec(4'b1010);
        chk("jm_exec", {mem_req, pc_write}, 2'b00);
        tick();
        chk("jm_mem_ack", {mem_req, pc_write, pc_src, mem_we}, 5'b11100);
        tick();
        chk("jm_refetch", {mem_req, mem_addr_sel, retired}, 6'b101010);
        fetch_to_exec(4'b0011);
        chk("st_exec", {mem_we, reg_write, alu_src}, 3'b001);
        tick();
        chk("st_mem", {mem_req, mem_we, mem_addr_sel, reg_write}, 4'b1110);
        tick();
        chk("st_refetch", {mem_we, reg_write, retired}, 6'b001011);
        fetch_to_exec(4'b1111);
        tick();
        chk("svpc_wb", {reg_write, svpc, mem_to_reg}, 3'b110);
        tick();
        fetch_to_exec(4'b1000);
        chk("j_exec", {pc_write, pc_src}, 3'b101);
        tick();
        chk("j_retired", retired, 4'd13);

        // Retire counter wraps 15 -> 0
        for (int i = 0; i < 3; i++) begin
            fetch_to_exec(4'b0000);
            tick();
        end
        chk("retired_wrap", retired, 4'd0);

        // 6a. Fetch timeout: no ack for 4 request cycles
        mem_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("to_fetch4", {mem_req, halted}, 2'b10);
        tick();
        chk("to_halt", {halted, err_timeout, err_illegal, mem_req}, 4'b1100);
        mem_ack = 1'b1;
        tick();
        chk("to_halt_hold", {halted, err_timeout, mem_req, ir_load}, 4'b1100);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("to_rst_clear", {halted, err_timeout, err_illegal, mem_req, retired}, 8'h00);

        // 6b. Ack arrives on the 4th fetch cycle: no timeout
        mem_ack = 1'b0;
        tick();
        tick();
        tick();
        tick();
        fetch_to_exec(4'b0000);
        chk("late_ack_ok", {halted, err_timeout}, 2'b00);
        tick();
        chk("late_ack_retired", retired, 4'd1);

        // 5. Illegal opcode
        mem_ack = 1'b1; opcode = 4'b1100;
        tick();
        tick();
        chk("ill_halt", {halted, err_illegal, err_timeout, mem_req}, 4'b1100);
        tick();
        tick();
        chk("ill_hold", {halted, err_illegal, mem_req, pc_write}, 4'b1100);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("ill_rst_clear", {halted, err_illegal, mem_req}, 3'b000);

        // 6c. Reset in the middle of a MEM wait
        tick();
        fetch_to_exec(4'b1110);
        mem_ack = 1'b0;
        tick();
        chk("mid_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_mem_rst", {mem_req, mem_addr_sel, halted}, 3'b000);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the SCU datapath. It replaces per-instruction single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence, so one unified memory port serves both instruction fetch and data access. It holds the Z/N condition flags, resolves branches and jumps, applies a memory-ack timeout, and halts on illegal opcodes.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ack in FETCH/MEM before error halt (≥1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
opcode  in  4  instr[31:28]; valid from DECODE onward, since the datapath IR is loaded by ir_load
alu_z  in  1  ALU result == 0 (combinational, EXEC)
alu_n  in  1  ALU result sign bit (combinational, EXEC)
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write strobe (store)
mem_addr_sel  out  1  0 = PC, 1 = register/ALU address
ir_load  out  1  capture instruction word into IR
pc_write  out  1  update PC
pc_src  out  2  00 = PC+1, 01 = register target, 10 = memory data
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU
alu_src  out  1  0 = register, 1 = immediate/constant
alu_op  out  4  ALU function
svpc  out  1  writeback source = PC + offset
halted  out  1  sticky halt
err_illegal  out  1  halt cause: illegal opcode
err_timeout  out  1  halt cause: mem_ack timeout
retired  out  CNT_W  completed-instruction count, wraps

Behaviour:
- Opcodes: NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111. Illegal: 0001, 0010, 1100, 1101.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore-decoded from state plus the opcode latched in DECODE (op_q).
- Reset: state = IDLE. All outputs 0 except alu_op = 0100. Flags Z = N = 0, retired = 0, timeout counter = 0. Reset in any state, including mid-handshake, aborts immediately: mem_req drops the cycle after rst is sampled.
- IDLE: one cycle, then FETCH.
- FETCH: mem_req = 1, mem_addr_sel = 0.
  - On mem_ack: ir_load = 1, pc_write = 1, pc_src = 00 (same cycle); next state DECODE.
- DECODE: latch op_q = opcode.
  - Illegal opcode → HALT, err_illegal = 1.
  - Otherwise → EXEC.
- EXEC:
  - ADD/INC/NEG/SUB: alu_op = op_q; alu_src = 1 for INC/NEG. Z <= alu_z and N <= alu_n at the end of this cycle. Next state WB.
  - LD/ST/JM: alu_op = 0100, alu_src = 1 for LD/ST (address calc). Next state MEM.
  - SVPC: next state WB.
  - J: pc_write = 1, pc_src = 01; next state FETCH.
  - BRZ: if Z, pc_write = 1 and pc_src = 01. BRN: same with N. Both use the flags as held at EXEC entry. Next state FETCH.
  - NOP: next state FETCH.
  - Flags change only on ALU ops.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = 1 for ST.
  - On mem_ack: ST → FETCH; LD → WB; JM → pc_write = 1, pc_src = 10 (same cycle), then FETCH.
- WB: reg_write = 1 for one cycle.
  - mem_to_reg = 1 for LD.
  - svpc = 1 for SVPC.
  - Next state FETCH.
- Handshake rules:
  - mem_req stays high until the cycle mem_ack = 1; the request completes in that cycle.
  - mem_ack while mem_req = 0 is ignored.
- Timeout counter:
  - Clears on entry to FETCH or MEM and increments each cycle without ack.
  - If MEM_TIMEOUT wait cycles pass with no ack → HALT, err_timeout = 1.
  - An ack arriving in the same cycle the counter reaches the limit wins (no timeout).
- retired: +1 on every transition into FETCH from EXEC, MEM or WB. Wraps at 2^CNT_W − 1 → 0.
- HALT: all strobes 0, halted = 1; the error bit holds until rst.
- Instruction latencies (mem_ack in the first request cycle):
  - NOP/J/BR: 3 cycles.
  - ALU/SVPC/ST/JM: 4 cycles.
  - LD: 5 cycles.

Decomposition:
- Package scu_pkg: opcode localparams, alu_op codes (ADD 0100, INC 0101, NEG 0110, SUB 0111), pc_src encodings, state enum.
- One natural sub-module: seq_mem_timer (timeout counter with clear/enable/expired), reused for fetch and data waits.

Test Plan:
1. Reset, mem_ack tied high, program NOP → 3 cycles/instr; retired = 1 after cycle 4 from rst release; mem_req first high in cycle 2.
2. SUB producing zero (alu_z = 1), then BRZ → pc_write = 1, pc_src = 01 in BRZ EXEC. Then ADD with alu_z = 0, BRZ → no pc_write.
3. LD with mem_ack delayed 3 cycles in MEM → mem_req high 4 cycles, mem_addr_sel = 1, then WB with reg_write = 1, mem_to_reg = 1; total 8 cycles.
4. JM → MEM ack cycle shows pc_write = 1, pc_src = 10; next state FETCH; ST → mem_we = 1 only in MEM; reg_write never asserted.
5. Opcode 1100 → HALT after DECODE, err_illegal = 1, halted = 1, no further mem_req; rst → IDLE, errors cleared.
6. MEM_TIMEOUT = 4, mem_ack held low in FETCH → err_timeout = 1 after 4 wait cycles. Repeat with ack exactly on the 4th cycle → no error. Assert rst mid-MEM → mem_req = 0 next cycle.
